// File: rtl/field_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// field_cursor_ctrl
//
// Edit-cursor controller for the clock/date/stopwatch setting path. Turns
// debounced button pulses plus the current display group into the 4-bit field
// code that drives the downstream one-hot flag decoder. Owns the IDLE/EDIT
// state machine, the 3-position cursor and the inactivity timeout.
//
// Ports
//   clk            system clock, all state on the rising edge
//   reset          asynchronous, active-high reset
//   btn_edit       1-cycle pulse, enter/leave edit mode
//   btn_right      1-cycle pulse, cursor to next field
//   btn_left       1-cycle pulse, cursor to previous field
//   mode[1:0]      display group: 00 hour, 01 date, 10 stopwatch, 11 none
//   field_sel[3:0] field code to the flag decoder, 4'hF when not editing
//   editing        high while in EDIT
//   field_changed  1-cycle strobe whenever field_sel takes a new value
//
// State table
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | not editing; field_sel parked at 4'hF, cursor and timer at 0
//   ST_EDIT | editing field (group base + cursor); timer counts idle cycles
// -----------------------------------------------------------------------------
module field_cursor_ctrl #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_edit,
   input  logic       btn_right,
   input  logic       btn_left,
   input  logic [1:0] mode,
   output logic [3:0] field_sel,
   output logic       editing,
   output logic       field_changed
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    FS_NONE  = 4'hF;
   localparam logic [1:0]    MODE_NONE = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EDIT = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [1:0]    r_idx;
   logic [1:0]    w_idx_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [1:0]    r_mode_q;
   logic [3:0]    r_field_sel;
   logic          r_field_changed;

   logic          w_any_btn;
   logic          w_exit;
   logic [3:0]    w_base;
   logic [3:0]    w_fs_nxt;

   assign w_any_btn = btn_edit | btn_right | btn_left;

   // Group base; code 6 is a gap between date and stopwatch fields.
   always_comb begin
      w_base = 4'd0;
      unique case (mode)
         2'b00:   w_base = 4'd0;
         2'b01:   w_base = 4'd3;
         2'b10:   w_base = 4'd7;
         default: w_base = 4'd0;
      endcase
   end

   // Exit priority inside EDIT: mode change, then btn_edit, then timeout.
   // An arrow in the last counted cycle is activity and keeps us editing.
   assign w_exit = (mode != r_mode_q) | btn_edit |
                   ((r_cnt == CNT_LAST) & ~w_any_btn);

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         ST_IDLE: begin
            w_idx_nxt = 2'd0;
            w_cnt_nxt = '0;
            if (btn_edit && (mode != MODE_NONE)) begin
               w_state_nxt = ST_EDIT;
            end
         end
         ST_EDIT: begin
            if (w_exit) begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = 2'd0;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = w_any_btn ? '0 : r_cnt + CW'(1);
               // Left+right together cancel out: no move, but still activity.
               if (btn_right && !btn_left) begin
                  w_idx_nxt = (r_idx >= 2'd2) ? 2'd0 : r_idx + 2'd1;
               end else if (btn_left && !btn_right) begin
                  w_idx_nxt = (r_idx == 2'd0) ? 2'd2 : r_idx - 2'd1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 2'd0;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Staying in EDIT implies mode == mode_q, so the live mode gives the base.
   assign w_fs_nxt = (w_state_nxt == ST_EDIT) ? (w_base + {2'b00, w_idx_nxt})
                                              : FS_NONE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_idx           <= 2'd0;
         r_cnt           <= '0;
         r_mode_q        <= MODE_NONE;
         r_field_sel     <= FS_NONE;
         r_field_changed <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_idx           <= w_idx_nxt;
         r_cnt           <= w_cnt_nxt;
         r_mode_q        <= mode;
         r_field_sel     <= w_fs_nxt;
         r_field_changed <= (w_fs_nxt != r_field_sel);
      end
   end

   assign field_sel     = r_field_sel;
   assign editing       = (r_state == ST_EDIT);
   assign field_changed = r_field_changed;

endmodule

// File: tb/tb_field_cursor_ctrl.sv
module tb_field_cursor_ctrl;

   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_edit, btn_right, btn_left;
   logic [1:0] mode;
   logic [3:0] field_sel;
   logic       editing, field_changed;

   int n_checks = 0;
   int n_fail   = 0;

   field_cursor_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .btn_edit(btn_edit), .btn_right(btn_right),
      .btn_left(btn_left), .mode(mode), .field_sel(field_sel),
      .editing(editing), .field_changed(field_changed)
   );

   always #5 clk = ~clk;

   // scoreboard: {field_sel, editing, field_changed}
   logic [5:0] exp_q[$];
   logic [5:0] obs_q[$];

   // reference model
   int         codes [3][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{7, 8, 9}};
   bit         m_edit;
   int         m_idx, m_cnt;
   logic [1:0] m_modeq;
   logic [3:0] m_fs;
   logic       m_fc;

   task automatic model_reset();
      m_edit = 0; m_idx = 0; m_cnt = 0; m_modeq = 2'b11; m_fs = 4'hF; m_fc = 0;
   endtask

   task automatic model_leave();
      m_edit = 0; m_idx = 0; m_cnt = 0;
   endtask

   task automatic step(input logic e, input logic r, input logic l, input logic [1:0] m);
      logic [3:0] fs_new;
      bit any;
      btn_edit = e; btn_right = r; btn_left = l; mode = m;
      any = e | r | l;
      if (m_edit && m != m_modeq) model_leave();
      else if (e) begin
         if (m_edit) model_leave();
         else if (m != 2'b11) begin m_edit = 1; m_idx = 0; m_cnt = 0; end
      end else if (m_edit && m_cnt == TO - 1 && !any) model_leave();
      else if (m_edit) begin
         m_cnt = any ? 0 : m_cnt + 1;
         if (r && !l) m_idx = (m_idx + 1) % 3;
         if (l && !r) m_idx = (m_idx + 2) % 3;
      end
      m_modeq = m;
      fs_new = (m_edit && m != 2'b11) ? 4'(codes[m][m_idx]) : 4'hF;
      m_fc = (fs_new != m_fs);
      m_fs = fs_new;
      exp_q.push_back({m_fs, m_edit, m_fc});
      @(posedge clk); #1;
      obs_q.push_back({field_sel, editing, field_changed});
      btn_edit = 0; btn_right = 0; btn_left = 0;
   endtask

   task automatic test_reset();
      logic [5:0] e, o;
      reset = 1; btn_edit = 0; btn_right = 0; btn_left = 0; mode = 2'b00;
      model_reset();
      #2;
      n_checks++;
      if ({field_sel, editing, field_changed} !== 6'b1111_0_0) begin
         n_fail++;
         $display("FAIL reset_vals: got fs=%h ed=%b fc=%b want fs=f ed=0 fc=0", field_sel, editing, field_changed);
      end
      @(posedge clk); #1; reset = 0;
      step(0, 0, 0, 2'b00);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL reset_sb: got fs=%h ed=%b fc=%b want fs=%h ed=%b fc=%b", o[5:2], o[1], o[0], e[5:2], e[1], e[0]); end
      end
   endtask

   task automatic test_hour();
      logic [5:0] e, o;
      int want [3] = '{1, 2, 0};
      step(1, 0, 0, 2'b00);
      n_checks++;
      if (field_sel !== 4'd0 || editing !== 1'b1 || field_changed !== 1'b1) begin
         n_fail++; $display("FAIL hour_enter: got fs=%h ed=%b fc=%b want 0 1 1", field_sel, editing, field_changed);
      end
      step(0, 0, 0, 2'b00);
      n_checks++;
      if (field_changed !== 1'b0) begin n_fail++; $display("FAIL hour_strobe_len: got fc=%b want 0", field_changed); end
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 2'b00);
         n_checks++;
         if (field_sel !== 4'(want[i])) begin n_fail++; $display("FAIL hour_right%0d: got fs=%0d want %0d", i, field_sel, want[i]); end
      end
      step(1, 0, 0, 2'b00);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL hour_sb: got fs=%h ed=%b fc=%b want fs=%h ed=%b fc=%b", o[5:2], o[1], o[0], e[5:2], e[1], e[0]); end
      end
   endtask

   task automatic test_stopwatch();
      logic [5:0] e, o;
      int want [4] = '{9, 8, 9, 7};
      bit mv [4] = '{1, 1, 0, 0};   // 1 = left
      logic [1:0] gm;
      logic r;
      step(0, 0, 0, 2'b10);
      step(1, 0, 0, 2'b10);
      for (int i = 0; i < 4; i++) begin
         step(0, !mv[i], mv[i], 2'b10);
         n_checks++;
         if (field_sel !== 4'(want[i])) begin n_fail++; $display("FAIL sw_arrow%0d: got fs=%0d want %0d", i, field_sel, want[i]); end
      end
      step(1, 0, 0, 2'b10);
      for (int g = 0; g < 2; g++) begin
         gm = (g == 0) ? 2'b01 : 2'b10;
         step(0, 0, 0, gm);
         step(1, 0, 0, gm);
         for (int i = 0; i < 20; i++) begin
            r = 1'($urandom_range(0, 1));
            step(0, r, !r, gm);
            n_checks++;
            if (field_sel === 4'd6) begin n_fail++; $display("FAIL no_code6: got fs=%0d want not 6", field_sel); end
         end
         step(1, 0, 0, gm);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL sw_sb: got fs=%h ed=%b fc=%b want fs=%h ed=%b fc=%b", o[5:2], o[1], o[0], e[5:2], e[1], e[0]); end
      end
   endtask

   task automatic test_timeout();
      logic [5:0] e, o;
      step(0, 0, 0, 2'b01);
      step(1, 0, 0, 2'b01);
      for (int i = 1; i <= TO; i++) begin
         step(0, 0, 0, 2'b01);
         n_checks++;
         if (editing !== (i < TO) || (i == TO && field_sel !== 4'hF)) begin
            n_fail++; $display("FAIL timeout_plain%0d: got ed=%b fs=%h want ed=%b", i, editing, field_sel, (i < TO));
         end
      end
      step(1, 0, 0, 2'b01);
      for (int i = 1; i <= 4; i++) step(0, 0, 0, 2'b01);
      step(0, 1, 0, 2'b01);
      for (int i = 1; i <= TO; i++) begin
         step(0, 0, 0, 2'b01);
         n_checks++;
         if (editing !== (i < TO)) begin
            n_fail++; $display("FAIL timeout_postponed%0d: got ed=%b want %b", i, editing, (i < TO));
         end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL timeout_sb: got fs=%h ed=%b fc=%b want fs=%h ed=%b fc=%b", o[5:2], o[1], o[0], e[5:2], e[1], e[0]); end
      end
   endtask

   task automatic test_mode_change();
      logic [5:0] e, o;
      step(1, 0, 0, 2'b01);
      step(0, 1, 0, 2'b01);
      n_checks++;
      if (field_sel !== 4'd4) begin n_fail++; $display("FAIL mc_setup: got fs=%0d want 4", field_sel); end
      step(0, 0, 0, 2'b00);
      n_checks++;
      if (editing !== 1'b0 || field_sel !== 4'hF) begin
         n_fail++; $display("FAIL mc_exit: got ed=%b fs=%h want ed=0 fs=f", editing, field_sel);
      end
      step(1, 0, 0, 2'b00);
      n_checks++;
      if (field_sel !== 4'd0 || editing !== 1'b1) begin n_fail++; $display("FAIL mc_reenter: got fs=%h ed=%b want 0 1", field_sel, editing); end
      step(1, 0, 0, 2'b00);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL mc_sb: got fs=%h ed=%b fc=%b want fs=%h ed=%b fc=%b", o[5:2], o[1], o[0], e[5:2], e[1], e[0]); end
      end
   endtask

   task automatic test_simultaneous();
      logic [5:0] e, o;
      step(1, 0, 0, 2'b00);
      step(0, 1, 0, 2'b00);
      step(1, 1, 0, 2'b00);
      n_checks++;
      if (editing !== 1'b0 || field_sel !== 4'hF) begin n_fail++; $display("FAIL edit_plus_right: got ed=%b fs=%h want 0 f", editing, field_sel); end
      step(1, 0, 0, 2'b00);
      step(0, 1, 0, 2'b00);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 2'b00);
      step(0, 1, 1, 2'b00);
      n_checks++;
      if (field_sel !== 4'd1 || field_changed !== 1'b0) begin
         n_fail++; $display("FAIL left_plus_right: got fs=%h fc=%b want 1 0", field_sel, field_changed);
      end
      for (int i = 1; i <= TO; i++) begin
         step(0, 0, 0, 2'b00);
         n_checks++;
         if (editing !== (i < TO)) begin n_fail++; $display("FAIL lr_counter_clear%0d: got ed=%b want %b", i, editing, (i < TO)); end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL simul_sb: got fs=%h ed=%b fc=%b want fs=%h ed=%b fc=%b", o[5:2], o[1], o[0], e[5:2], e[1], e[0]); end
      end
   endtask

   task automatic test_mode_none();
      logic [5:0] e, o;
      step(0, 0, 0, 2'b11);
      step(1, 0, 0, 2'b11);
      n_checks++;
      if (editing !== 1'b0 || field_sel !== 4'hF) begin n_fail++; $display("FAIL mode11_edit: got ed=%b fs=%h want 0 f", editing, field_sel); end
      step(0, 1, 0, 2'b11);
      step(0, 0, 1, 2'b00);
      n_checks++;
      if (field_sel !== 4'hF || field_changed !== 1'b0) begin n_fail++; $display("FAIL idle_arrow: got fs=%h fc=%b want f 0", field_sel, field_changed); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL mode11_sb: got fs=%h ed=%b fc=%b want fs=%h ed=%b fc=%b", o[5:2], o[1], o[0], e[5:2], e[1], e[0]); end
      end
   endtask

   task automatic test_reset_mid_edit();
      logic [5:0] e, o;
      step(0, 0, 0, 2'b10);
      step(1, 0, 0, 2'b10);
      step(0, 0, 1, 2'b10);
      step(0, 0, 1, 2'b10);
      n_checks++;
      if (field_sel !== 4'd8 || field_changed !== 1'b1) begin n_fail++; $display("FAIL rst_setup: got fs=%h fc=%b want 8 1", field_sel, field_changed); end
      #2 reset = 1;
      #1;
      n_checks++;
      if ({field_sel, editing, field_changed} !== 6'b1111_0_0) begin
         n_fail++; $display("FAIL rst_async: got fs=%h ed=%b fc=%b want f 0 0", field_sel, editing, field_changed);
      end
      model_reset();
      @(posedge clk); #1; reset = 0;
      step(0, 0, 0, 2'b10);
      step(1, 0, 0, 2'b10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL rst_sb: got fs=%h ed=%b fc=%b want fs=%h ed=%b fc=%b", o[5:2], o[1], o[0], e[5:2], e[1], e[0]); end
      end
   endtask

   initial begin
      test_reset();
      test_hour();
      test_stopwatch();
      test_timeout();
      test_mode_change();
      test_simultaneous();
      test_mode_none();
      test_reset_mid_edit();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
